// File: rtl/frame_capture_player.sv
`default_nettype none
// ============================================================================
// Module   : frame_capture_player
// Brief    : Captures FRAME_LEN strobed words into a buffer, checks the
//            capturer error flag at frame end, then replays one word per
//            INTERVAL cycles. Define LOOP_PLAY_EN for continuous replay.
// Revision : 1.0 - initial release
// ============================================================================
module frame_capture_player #(
    parameter int DATA_W    = 1,
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = 5,
    parameter int INTERVAL  = 50000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              play,
    input  logic              abort,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data,
    input  logic              error,
    output logic              gen_en,
    output logic [2:0]        state,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_CAPTURE = 3'b001,
        S_READY   = 3'b010,
        S_ERROR   = 3'b011,
        S_PLAY    = 3'b100
    } state_t;

    localparam int               c_AW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] c_LEN       = IDX_W'(FRAME_LEN);
    localparam logic [31:0]      c_TICK_LAST = 32'(INTERVAL - 1);

    state_t            r_state;
    logic              r_strb_s1;
    logic              r_strb_s2;
    logic              r_strb_d;
    logic [IDX_W-1:0]  r_wr_cnt;
    logic [IDX_W-1:0]  r_rd_cnt;
    logic [31:0]       r_tick_cnt;
    logic [IDX_W-1:0]  r_out_idx;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_buf [FRAME_LEN];
    logic              w_strb_rise;

    assign w_strb_rise = r_strb_s2 & ~r_strb_d;
    assign gen_en      = (r_state == S_CAPTURE);
    assign state       = r_state;
    assign out_idx     = r_out_idx;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= S_IDLE;
            r_strb_s1   <= 1'b0;
            r_strb_s2   <= 1'b0;
            r_strb_d    <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_tick_cnt  <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) r_buf[i] <= '0;
        end else begin
            r_strb_s1   <= strobe;
            r_strb_s2   <= r_strb_s1;
            r_strb_d    <= r_strb_s2;
            r_out_valid <= 1'b0;

            if (abort) begin
                r_state    <= S_IDLE;
                r_wr_cnt   <= '0;
                r_rd_cnt   <= '0;
                r_tick_cnt <= '0;
                r_out_idx  <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (start) begin
                            r_state  <= S_CAPTURE;
                            r_wr_cnt <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        if (start) begin
                            r_wr_cnt <= '0;
                        end else if (w_strb_rise) begin
                            if (r_wr_cnt < c_LEN) begin
                                r_buf[r_wr_cnt[c_AW-1:0]] <= data;
                                r_wr_cnt <= r_wr_cnt + IDX_W'(1);
                            end else begin
                                // The edge after the last word carries the frame verdict
                                r_wr_cnt <= '0;
                                r_state  <= error ? S_ERROR : S_READY;
                            end
                        end
                    end
                    S_READY: begin
                        if (start) begin
                            r_state  <= S_CAPTURE;
                            r_wr_cnt <= '0;
                        end else if (play) begin
                            r_state    <= S_PLAY;
                            r_tick_cnt <= '0;
                            r_rd_cnt   <= '0;
                        end
                    end
                    S_PLAY: begin
                        if (r_tick_cnt == c_TICK_LAST) begin
                            r_tick_cnt <= '0;
                            if (r_rd_cnt < c_LEN) begin
                                r_out_data  <= r_buf[r_rd_cnt[c_AW-1:0]];
                                r_out_idx   <= r_rd_cnt + IDX_W'(1);
                                r_out_valid <= 1'b1;
                                r_rd_cnt    <= r_rd_cnt + IDX_W'(1);
                            end else begin
                                r_out_idx <= '0;
                                r_rd_cnt  <= '0;
`ifndef LOOP_PLAY_EN
                                r_state   <= S_READY;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 32'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_capture_player
// Brief    : Randomised scoreboard bench for frame_capture_player.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_capture_player;

    localparam int DATA_W    = 2;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 3;
    localparam int INTERVAL  = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              start = 1'b0, play = 1'b0, abort = 1'b0;
    logic              strobe = 1'b0, error = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              gen_en;
    logic [2:0]        state;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    frame_capture_player #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W), .INTERVAL(INTERVAL)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .play(play),
        .abort(abort), .strobe(strobe), .data(data), .error(error),
        .gen_en(gen_en), .state(state), .out_idx(out_idx),
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int idx;
        int dat;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   stim  [FRAME_LEN];
    int   frame [FRAME_LEN];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every replayed word must match the queue head
    always @(negedge sys_clk) begin
        if (sys_rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_qsize", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("replay_idx", int'(out_idx), e.idx);
                check("replay_data", int'(out_data), e.dat);
                check("replay_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic pulse_start();
        @(negedge sys_clk) start = 1'b1;
        @(negedge sys_clk) start = 1'b0;
    endtask

    task automatic pulse_play();
        @(negedge sys_clk) play = 1'b1;
        @(negedge sys_clk) play = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge sys_clk) abort = 1'b1;
        @(negedge sys_clk) abort = 1'b0;
    endtask

    task automatic send_word(input int d);
        @(negedge sys_clk);
        data   = DATA_W'(d);
        strobe = 1'b1;
        repeat (4) @(negedge sys_clk);
        strobe = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    // Full capture of stim[] followed by the verdict edge carrying err
    task automatic capture_frame(input bit err);
        pulse_start();
        check("cap_state", int'(state), 1);
        check("cap_gen_en", int'(gen_en), 1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            send_word(stim[i]);
            frame[i] = stim[i];
        end
        check("cap_state_before_verdict", int'(state), 1);
        error = err;
        send_word(int'($urandom_range(0, (1 << DATA_W) - 1)));
        error = 1'b0;
        check("verdict_state", int'(state), err ? 3 : 2);
        check("verdict_gen_en", int'(gen_en), 0);
    endtask

    task automatic play_frame();
        int t0;
        pulse_play();
        t0 = cyc;
        check("play_state", int'(state), 4);
        for (int k = 1; k <= FRAME_LEN; k++)
            exp_q.push_back('{idx: k, dat: frame[k-1], cyc: t0 + k * INTERVAL});
`ifdef LOOP_PLAY_EN
        for (int k = 1; k <= FRAME_LEN; k++)
            exp_q.push_back('{idx: k, dat: frame[k-1],
                              cyc: t0 + (FRAME_LEN + 1 + k) * INTERVAL});
        repeat ((2 * FRAME_LEN + 1) * INTERVAL + 2) @(negedge sys_clk);
        check("loop_qsize", exp_q.size(), 0);
        pulse_abort();
        check("loop_abort_state", int'(state), 0);
        check("loop_abort_idx", int'(out_idx), 0);
`else
        repeat ((FRAME_LEN + 1) * INTERVAL + 2) @(negedge sys_clk);
        check("replay_qsize", exp_q.size(), 0);
        check("end_state", int'(state), 2);
        check("end_out_idx", int'(out_idx), 0);
        check("end_out_data_hold", int'(out_data), frame[FRAME_LEN-1]);
`endif
    endtask

    initial begin
        #1;
        check("rst_state", int'(state), 0);
        check("rst_gen_en", int'(gen_en), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;

        // Strobes before start must not disturb IDLE
        send_word(3);
        check("idle_ignores_strobe", int'(state), 0);

        stim[0] = 1; stim[1] = 2; stim[2] = 3; stim[3] = 0;
        capture_frame(1'b0);
        play_frame();

        for (int it = 0; it < 6; it++) begin
            bit err;
            for (int i = 0; i < FRAME_LEN; i++)
                stim[i] = int'($urandom_range(0, (1 << DATA_W) - 1));
            err = ($urandom_range(0, 2) == 0);
            capture_frame(err);
            if (err) begin
                pulse_play();
                check("error_ignores_play", int'(state), 3);
                pulse_start();
                check("error_restart_state", int'(state), 1);
                pulse_abort();
                check("error_abort_state", int'(state), 0);
            end else begin
                play_frame();
            end
        end

        // Abort part-way through a capture
        pulse_start();
        send_word(1);
        send_word(2);
        pulse_abort();
        check("abort_state", int'(state), 0);
        check("abort_gen_en", int'(gen_en), 0);
        send_word(3);
        send_word(1);
        check("abort_ignores_strobe", int'(state), 0);

        // Asynchronous reset while replaying
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = int'($urandom_range(1, 3));
        capture_frame(1'b0);
        pulse_play();
        exp_q.push_back('{idx: 1, dat: frame[0], cyc: cyc + INTERVAL});
        repeat (INTERVAL + 2) @(negedge sys_clk);
        check("pre_reset_qsize", exp_q.size(), 0);
        #2 sys_rst = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_out_idx", int'(out_idx), 0);
        check("async_rst_out_data", int'(out_data), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_gen_en", int'(gen_en), 0);
        exp_q.delete();
        @(negedge sys_clk) sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
